// File: rtl/prbs_ber_pkg.sv
// Shared PRBS9 tap constants, checker state encoding and a constant clog2 helper
// for the PRBS bit-error-rate checker.
package prbs_ber_pkg;

    localparam int PRBS_LEN = 9;
    localparam int PRBS_TAP = 5;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 (x^9+x^5+1) shift register: loads received bits while searching and
// free-runs on its own prediction once locked.
module prbs9_lfsr
    import prbs_ber_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load_mode,
    input  logic in_bit,
    output logic pred,
    output logic zero
);

    logic [PRBS_LEN-1:0] lfsr_reg;

    assign pred = lfsr_reg[PRBS_LEN-1] ^ lfsr_reg[PRBS_TAP-1];
    assign zero = (lfsr_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= '0;
        end else if (en) begin
            lfsr_reg <= {lfsr_reg[PRBS_LEN-2:0], (load_mode ? in_bit : pred)};
        end
    end

endmodule

// File: rtl/prbs_ber_checker.sv
// Decimating PAM2 slicer with self-synchronising PRBS9 BER checker.
// Optional runtime sample-phase select: define PRBS_BER_CHECKER_PHASE_SEL_EN.
module prbs_ber_checker
    import prbs_ber_pkg::*;
#(
    parameter int W        = 16,
    parameter int DATA_F   = 7,
    parameter int OS       = 4,
    parameter int PHASE    = 0,
    parameter int LOCK_WIN = 64,
    parameter int LOSS_THR = 16,
    parameter int CNT_W    = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic signed [W-1:0]                     din,
    input  logic                                    clr_cnt,
`ifdef PRBS_BER_CHECKER_PHASE_SEL_EN
    input  logic [((OS > 1) ? clog2(OS) : 1)-1:0]   phase_sel,
`endif
    output logic                                    sym_valid,
    output logic                                    sym_bit,
    output logic                                    lock,
    output logic [CNT_W-1:0]                        bit_cnt,
    output logic [CNT_W-1:0]                        err_cnt
);

    localparam int PH_W   = (OS > 1) ? clog2(OS) : 1;
    localparam int MW     = clog2(LOCK_WIN + 1);
    localparam int EW     = clog2(LOSS_THR + 1);
    localparam int FILL_W = clog2(PRBS_LEN + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);

    logic [PH_W-1:0]   ph_cnt_reg;
    logic [PH_W-1:0]   phase_cur;
    logic              sym_valid_reg;
    logic              sym_bit_reg;
    state_t            state_reg,   state_next;
    logic [FILL_W-1:0] fill_reg,    fill_next;
    logic [MW-1:0]     match_reg,   match_next;
    logic [MW-1:0]     win_cnt_reg, win_cnt_next;
    logic [EW-1:0]     win_err_reg, win_err_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0]  err_cnt_reg, err_cnt_next;
    logic              lfsr_en;
    logic              lfsr_load;
    logic              lfsr_pred;
    logic              lfsr_zero;
    logic              sym_err;
    logic              unused_bits;

    // Only the sign bit decides the symbol; the fractional format is informational.
    assign unused_bits = ^{din[W-2:0], DATA_F[0]};

`ifdef PRBS_BER_CHECKER_PHASE_SEL_EN
    logic [PH_W-1:0] phase_reg;

    // Captured at the end of a symbol period so the slice point never moves mid-symbol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= PH_W'(PHASE);
        end else if (ph_cnt_reg == PH_LAST) begin
            phase_reg <= (int'(phase_sel) >= OS) ? PH_LAST : phase_sel;
        end
    end

    assign phase_cur = phase_reg;
`else
    assign phase_cur = PH_W'(PHASE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_cnt_reg    <= '0;
            sym_valid_reg <= 1'b0;
            sym_bit_reg   <= 1'b0;
        end else begin
            ph_cnt_reg    <= (ph_cnt_reg == PH_LAST) ? '0 : ph_cnt_reg + PH_W'(1);
            sym_valid_reg <= (ph_cnt_reg == phase_cur);
            if (ph_cnt_reg == phase_cur) begin
                sym_bit_reg <= din[W-1];
            end
        end
    end

    prbs9_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .en        (lfsr_en),
        .load_mode (lfsr_load),
        .in_bit    (sym_bit_reg),
        .pred      (lfsr_pred),
        .zero      (lfsr_zero)
    );

    assign sym_err = sym_bit_reg ^ lfsr_pred;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= SEARCH;
            fill_reg    <= '0;
            match_reg   <= '0;
            win_cnt_reg <= '0;
            win_err_reg <= '0;
            bit_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            fill_reg    <= fill_next;
            match_reg   <= match_next;
            win_cnt_reg <= win_cnt_next;
            win_err_reg <= win_err_next;
            bit_cnt_reg <= bit_cnt_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        fill_next    = fill_reg;
        match_next   = match_reg;
        win_cnt_next = win_cnt_reg;
        win_err_next = win_err_reg;
        bit_cnt_next = bit_cnt_reg;
        err_cnt_next = err_cnt_reg;
        lfsr_en      = sym_valid_reg;
        lfsr_load    = 1'b1;

        if (sym_valid_reg) begin
            unique case (state_reg)
                SEARCH: begin
                    lfsr_load = 1'b1;
                    if (fill_reg != FILL_W'(PRBS_LEN)) begin
                        fill_next = fill_reg + FILL_W'(1);
                    end else if (lfsr_zero || sym_err) begin
                        // An all-zero register predicts zeros forever, so it must never lock.
                        match_next = '0;
                    end else begin
                        match_next = match_reg + MW'(1);
                        if (match_next == MW'(LOCK_WIN)) begin
                            state_next   = LOCKED;
                            win_cnt_next = '0;
                            win_err_next = '0;
                        end
                    end
                end
                LOCKED: begin
                    lfsr_load = 1'b0;
                    if (bit_cnt_reg != '1) begin
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                    end
                    if (sym_err && (err_cnt_reg != '1)) begin
                        err_cnt_next = err_cnt_reg + CNT_W'(1);
                    end
                    win_cnt_next = win_cnt_reg + MW'(1);
                    if (sym_err && (win_err_reg != '1)) begin
                        win_err_next = win_err_reg + EW'(1);
                    end
                    if (win_cnt_next == MW'(LOCK_WIN)) begin
                        if (win_err_next >= EW'(LOSS_THR)) begin
                            state_next = SEARCH;
                            fill_next  = '0;
                            match_next = '0;
                        end
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end

        if (clr_cnt) begin
            bit_cnt_next = '0;
            err_cnt_next = '0;
        end
    end

    assign sym_valid = sym_valid_reg;
    assign sym_bit   = sym_bit_reg;
    assign lock      = (state_reg == LOCKED);
    assign bit_cnt   = bit_cnt_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Directed bench for prbs_ber_checker: slicer boundaries, lock acquisition,
// sparse and burst errors, counter clear and asynchronous reset.
module tb_prbs_ber_checker;

    localparam int OS = 4;

    logic               clk;
    logic               rst;
    logic signed [15:0] din;
    logic signed [15:0] din2;
    logic               clr_cnt;
    logic               clr2;
    logic               sym_valid, sym_bit, lock;
    logic [31:0]        bit_cnt, err_cnt;
    logic               sym_valid2, sym_bit2, lock2;
    logic [31:0]        bit_cnt2, err_cnt2;

    int checks   = 0;
    int failures = 0;

    logic [8:0] gen_reg;
    logic       sv0, sv1, lk0, lk1;
    logic [31:0] bc1, ec1;
    int         sv_count, sb_bad, sv_bad;
    logic       lock_seen, lock_low;

    prbs_ber_checker #(.W(16), .DATA_F(7), .OS(OS), .PHASE(0),
                       .LOCK_WIN(64), .LOSS_THR(16), .CNT_W(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .clr_cnt   (clr_cnt),
`ifdef PRBS_BER_CHECKER_PHASE_SEL_EN
        .phase_sel (2'd0),
`endif
        .sym_valid (sym_valid),
        .sym_bit   (sym_bit),
        .lock      (lock),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    prbs_ber_checker #(.W(16), .DATA_F(7), .OS(OS), .PHASE(2),
                       .LOCK_WIN(64), .LOSS_THR(16), .CNT_W(32)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .din       (din2),
        .clr_cnt   (clr2),
`ifdef PRBS_BER_CHECKER_PHASE_SEL_EN
        .phase_sel (2'd2),
`endif
        .sym_valid (sym_valid2),
        .sym_bit   (sym_bit2),
        .lock      (lock2),
        .bit_cnt   (bit_cnt2),
        .err_cnt   (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic next_prbs(output logic b);
        b       = gen_reg[8] ^ gen_reg[4];
        gen_reg = {gen_reg[7:0], b};
    endtask

    // One symbol on the main DUT: bit 0 -> +64, bit 1 -> -64, held OS cycles.
    task automatic send_sym(input logic b, input logic clr);
        for (int i = 0; i < OS; i++) begin
            din     = b ? -16'sd64 : 16'sd64;
            clr_cnt = clr && (i == 1);
            @(posedge clk);
            #1;
            if (sym_valid) sv_count++;
            if (lock) lock_seen = 1'b1;
            else lock_low = 1'b1;
            if (i == 0) begin
                sv0 = sym_valid;
                lk0 = lock;
                if (sym_bit !== b) sb_bad++;
            end
            if (i == 1) begin
                sv1 = sym_valid;
                lk1 = lock;
                bc1 = bit_cnt;
                ec1 = err_cnt;
            end
        end
        clr_cnt = 1'b0;
        if (!(sv0 === 1'b1 && sv1 === 1'b0)) sv_bad++;
    endtask

    task automatic send_clean();
        logic b;
        next_prbs(b);
        send_sym(b, 1'b0);
    endtask

    // One symbol period on the PHASE=2 DUT; only s2 may decide the bit.
    task automatic send_group(input logic [15:0] s0, input logic [15:0] s1,
                              input logic [15:0] s2, input logic [15:0] s3,
                              input logic exp_bit, input string tag);
        logic [15:0] s [4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < OS; i++) begin
            din2 = s[i];
            @(posedge clk);
            #1;
            if (i == 0) check_val({tag, "_idle"}, 64'(sym_valid2), 64'd0);
            if (i == 2) begin
                check_val({tag, "_valid"}, 64'(sym_valid2), 64'd1);
                check_val({tag, "_bit"}, 64'(sym_bit2), 64'(exp_bit));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int sv_base;
        logic b;
        rst = 1'b1; din = 16'sd64; din2 = '0; clr_cnt = 1'b0; clr2 = 1'b0;
        sv_count = 0; sb_bad = 0; sv_bad = 0; lock_seen = 1'b0; lock_low = 1'b0;
        gen_reg = 9'h1FF;

        @(posedge clk);
        #1;
        check_val("rst_sym_valid", 64'(sym_valid), 64'd0);
        check_val("rst_sym_bit", 64'(sym_bit), 64'd0);
        check_val("rst_lock", 64'(lock), 64'd0);
        check_val("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        check_val("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Slicer boundaries on the PHASE=2 instance
        send_group(-16'sd100, -16'sd100, 16'h0000, -16'sd100, 1'b0, "slice_zero");
        send_group(16'sd100, 16'sd100, 16'hFFFF, 16'sd100, 1'b1, "slice_m1");
        send_group(16'sd100, 16'sd100, 16'h8000, 16'sd100, 1'b1, "slice_min");
        send_group(-16'sd5, -16'sd5, 16'sd5, -16'sd5, 1'b0, "slice_p5");

        // Degenerate constant input never locks
        lock_seen = 1'b0;
        sv_base   = sv_count;
        for (int k = 0; k < 1000; k++) send_sym(1'b0, 1'b0);
        check_val("degen_lock_seen", 64'(lock_seen), 64'd0);
        check_val("degen_bit_cnt", 64'(bit_cnt), 64'd0);
        check_val("sym_valid_count", 64'(sv_count - sv_base), 64'd1000);

        // Clean acquisition: 9 fill + 64 matches
        do_reset();
        for (int n = 1; n <= 73; n++) send_clean();
        check_val("lock_rise_before", 64'(lk0), 64'd0);
        check_val("lock_rise_after", 64'(lk1), 64'd1);
        check_val("lock_bit_cnt", 64'(bit_cnt), 64'd0);
        check_val("lock_err_cnt", 64'(err_cnt), 64'd0);

        // Sparse errors: one inverted symbol per 100
        lock_low = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            next_prbs(b);
            send_sym(b ^ ((k % 100) == 50), 1'b0);
            if (k == 50) check_val("sparse_first_err", 64'(err_cnt), 64'd1);
            if (k == 60) check_val("sparse_bits_61", 64'(bit_cnt), 64'd61);
        end
        check_val("sparse_lock_held", 64'(lock_low), 64'd0);
        check_val("sparse_bit_cnt", 64'(bit_cnt), 64'd10000);
        check_val("sparse_err_cnt", 64'(err_cnt), 64'd100);

        // Burst: 10000 locked symbols leave the window at 16; 8 clean + 20 bad + 20 clean closes it
        for (int k = 0; k < 8; k++) send_clean();
        for (int k = 0; k < 20; k++) begin
            next_prbs(b);
            send_sym(~b, 1'b0);
        end
        for (int k = 0; k < 19; k++) send_clean();
        check_val("burst_lock_kept", 64'(lock), 64'd1);
        send_clean();
        check_val("burst_drop_before", 64'(lk0), 64'd1);
        check_val("burst_drop_after", 64'(lk1), 64'd0);
        check_val("burst_bit_cnt", 64'(bit_cnt), 64'd10048);
        check_val("burst_err_cnt", 64'(err_cnt), 64'd120);
        for (int n = 1; n <= 73; n++) begin
            send_clean();
            if (n == 5) begin
                check_val("hold_bit_cnt", 64'(bit_cnt), 64'd10048);
                check_val("hold_err_cnt", 64'(err_cnt), 64'd120);
            end
        end
        check_val("relock_before", 64'(lk0), 64'd0);
        check_val("relock_after", 64'(lk1), 64'd1);

        // Clear on a counted symbol wins over the count
        for (int k = 0; k < 3; k++) send_clean();
        check_val("pre_clr_bit_cnt", 64'(bit_cnt), 64'd10051);
        next_prbs(b);
        send_sym(b, 1'b1);
        check_val("clr_bit_cnt", 64'(bc1), 64'd0);
        check_val("clr_err_cnt", 64'(ec1), 64'd0);
        next_prbs(b);
        send_sym(~b, 1'b0);
        check_val("post_clr_bit_cnt", 64'(bit_cnt), 64'd1);
        check_val("post_clr_err_cnt", 64'(err_cnt), 64'd1);

        // Asynchronous reset mid-cycle while locked
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_lock", 64'(lock), 64'd0);
        check_val("arst_bit_cnt", 64'(bit_cnt), 64'd0);
        check_val("arst_err_cnt", 64'(err_cnt), 64'd0);
        check_val("arst_sym_valid", 64'(sym_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 1; n <= 73; n++) send_clean();
        check_val("arst_relock_before", 64'(lk0), 64'd0);
        check_val("arst_relock_after", 64'(lk1), 64'd1);
        check_val("arst_relock_bits", 64'(bit_cnt), 64'd0);

        check_val("sym_bit_mismatches", 64'(sb_bad), 64'd0);
        check_val("sym_valid_pattern_bad", 64'(sv_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
